// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe retiming pipeline.
package reg_pipe_pkg;

    localparam int unsigned DEF_DATAWIDTH = 8;
    localparam int unsigned DEF_DEPTH     = 2;

    // Width needed to count 0..depth valid stages.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid+data register stage of reg_pipe; data only captured with a valid word.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 ld_i,
    input  logic                 valid_i,
    input  logic [DATAWIDTH-1:0] data_i,
    output logic                 valid_o,
    output logic [DATAWIDTH-1:0] data_o
);

    logic                 v_q;
    logic                 v_d;
    logic [DATAWIDTH-1:0] d_q;
    logic [DATAWIDTH-1:0] d_d;

    // Clear drops the valid bit but leaves data untouched so out_data stays put.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clr_i) begin
            v_d = 1'b0;
        end else if (ld_i) begin
            v_d = valid_i;
            if (valid_i) begin
                d_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign valid_o = v_q;
    assign data_o  = d_q;

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage valid/ready pipeline register with bubble collapsing and flush.
// Define REG_PIPE_OCC_EN to enable the registered occupancy counter.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter  int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter  int unsigned DEPTH     = DEF_DEPTH,
    localparam int unsigned OCC_W     = occ_w(DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [OCC_W-1:0]     occupancy
);

    logic [DEPTH-1:0]     v;
    logic [DEPTH-1:0]     rdy;
    logic [DATAWIDTH-1:0] d [DEPTH];

    // A stage can load if it is empty or the stage ahead of it is moving.
    always_comb begin : ready_chain
        logic r;
        rdy = '0;
        r   = !v[DEPTH-1] | out_ready;
        rdy[DEPTH-1] = r;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            r      = !v[i] | r;
            rdy[i] = r;
        end
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
        logic                 vin;
        logic [DATAWIDTH-1:0] din;

        if (g == 0) begin : g_head
            assign vin = in_valid;
            assign din = in_data;
        end else begin : g_body
            assign vin = v[g-1];
            assign din = d[g-1];
        end

        reg_pipe_stage #(
            .DATAWIDTH(DATAWIDTH)
        ) u_stage (
            .clk_i  (Clk),
            .rst_ni (Rst),
            .clr_i  (flush),
            .ld_i   (rdy[g]),
            .valid_i(vin),
            .data_i (din),
            .valid_o(v[g]),
            .data_o (d[g])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             push;
    logic             pop;

    // Words only enter at the head and leave at the tail, so a +/- count tracks popcount(v).
    always_comb begin
        push  = in_valid & in_ready;
        pop   = out_valid & out_ready;
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        if (flush) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`else
    assign occupancy = '0;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: directed cases on DEPTH=3/8b plus random traffic on both DUTs.
module tb_reg_pipe;

    localparam int unsigned A_DW    = 8;
    localparam int unsigned A_DEPTH = 3;
    localparam int unsigned B_DW    = 32;
    localparam int unsigned B_DEPTH = 1;

    logic clk = 1'b0;
    logic rst;

    logic              a_flush, a_iv, a_ir, a_ov, a_ordy;
    logic [A_DW-1:0]   a_id, a_od;
    logic [1:0]        a_occ;

    logic              b_flush, b_iv, b_ir, b_ov, b_ordy;
    logic [B_DW-1:0]   b_id, b_od;
    logic [0:0]        b_occ;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    logic [A_DW-1:0] rx_a [$];

    always #5 clk = ~clk;

    reg_pipe #(.DATAWIDTH(A_DW), .DEPTH(A_DEPTH)) u_dut_a (
        .Clk(clk), .Rst(rst), .flush(a_flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od),
        .occupancy(a_occ)
    );

    reg_pipe #(.DATAWIDTH(B_DW), .DEPTH(B_DEPTH)) u_dut_b (
        .Clk(clk), .Rst(rst), .flush(b_flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od),
        .occupancy(b_occ)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each DUT is an ordered list of in-flight words with a stage position.
    int unsigned m_dat [2][4];
    int          m_pos [2][4];
    int          m_cnt [2] = '{0, 0};

    function automatic int dep(input int k);
        return (k == 0) ? int'(A_DEPTH) : int'(B_DEPTH);
    endfunction

    function automatic bit m_ovalid(input int k);
        return (m_cnt[k] > 0) && (m_pos[k][0] == dep(k) - 1);
    endfunction

    // Each word moves one stage forward unless the word in front of it blocks it.
    function automatic void m_advance(input int k, input bit ordy, output bit pop, output int np[4]);
        int lim;
        lim = dep(k);
        pop = m_ovalid(k) && ordy;
        for (int j = 0; j < 4; j++) np[j] = 0;
        for (int j = 0; j < m_cnt[k]; j++) begin
            if (j == 0 && pop) np[j] = dep(k);
            else np[j] = (m_pos[k][j] + 1 < lim - 1) ? m_pos[k][j] + 1 : lim - 1;
            lim = np[j];
        end
    endfunction

    function automatic bit m_iready(input int k, input bit ordy, input bit fl);
        bit pop;
        int np[4];
        m_advance(k, ordy, pop, np);
        if (fl) return 1'b0;
        if (m_cnt[k] == 0) return 1'b1;
        return np[m_cnt[k] - 1] > 0;
    endfunction

    task automatic m_clock(input int k, input bit rs, input bit fl, input bit iv,
                           input int unsigned id, input bit ordy);
        bit          pop;
        bit          acc;
        int          np[4];
        int          n;
        int unsigned td[4];
        int          tp[4];
        if (!rs) begin
            m_cnt[k] = 0;
            return;
        end
        acc = iv && m_iready(k, ordy, fl);
        m_advance(k, ordy, pop, np);
        n = 0;
        for (int j = 0; j < m_cnt[k]; j++) begin
            if (!(j == 0 && pop)) begin
                td[n] = m_dat[k][j];
                tp[n] = np[j];
                n++;
            end
        end
        if (fl) n = 0;
        if (acc) begin
            td[n] = id;
            tp[n] = 0;
            n++;
        end
        for (int j = 0; j < n; j++) begin
            m_dat[k][j] = td[j];
            m_pos[k][j] = tp[j];
        end
        m_cnt[k] = n;
    endtask

    function automatic logic [31:0] occ_exp(input int n);
`ifdef REG_PIPE_OCC_EN
        return 32'(n);
`else
        return 32'(0 * n);
`endif
    endfunction

    always @(posedge clk) begin
        m_clock(0, rst, a_flush, a_iv, 32'(a_id), a_ordy);
        m_clock(1, rst, b_flush, b_iv, b_id, b_ordy);
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("a_out_valid", 32'(a_ov), 32'(m_ovalid(0)));
            if (m_ovalid(0)) check("a_out_data", 32'(a_od), m_dat[0][0]);
            check("a_occupancy", 32'(a_occ), occ_exp(m_cnt[0]));
            if (rst) check("a_in_ready", 32'(a_ir), 32'(m_iready(0, a_ordy, a_flush)));
            check("b_out_valid", 32'(b_ov), 32'(m_ovalid(1)));
            if (m_ovalid(1)) check("b_out_data", b_od, m_dat[1][0]);
            check("b_occupancy", 32'(b_occ), occ_exp(m_cnt[1]));
            if (rst) check("b_in_ready", 32'(b_ir), 32'(m_iready(1, b_ordy, b_flush)));
        end
        if (rst && a_ov && a_ordy) rx_a.push_back(a_od);
    end

    initial begin
        rst = 1'b0;
        a_flush = 1'b0; a_iv = 1'b1; a_id = 8'hAA; a_ordy = 1'b1;
        b_flush = 1'b0; b_iv = 1'b1; b_id = 32'hAA; b_ordy = 1'b1;

        // Reset held with traffic presented
        repeat (2) step();
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_a_ov", 32'(a_ov), 32'd0);
        check("rst_a_od", 32'(a_od), 32'd0);
        check("rst_a_occ", 32'(a_occ), 32'd0);
        check("rst_b_ov", 32'(b_ov), 32'd0);
        check("rst_b_od", b_od, 32'd0);
        step();
        rst = 1'b1; a_iv = 1'b0; b_iv = 1'b0;
        @(negedge clk);
        check("rst_a_ir", 32'(a_ir), 32'd1);
        check("rst_b_ir", 32'(b_ir), 32'd1);

        // Streaming 0x01..0x10 with latency pinned
        rx_a.delete();
        for (int n = 0; n < 16; n++) begin
            a_iv = 1'b1;
            a_id = 8'(n + 1);
            step();
            @(negedge clk);
            check("stream_ir", 32'(a_ir), 32'd1);
            if (n < 2) check("lat_not_yet", 32'(a_ov), 32'd0);
            if (n == 2) begin
                check("lat_valid", 32'(a_ov), 32'd1);
                check("lat_data", 32'(a_od), 32'h01);
            end
        end
        a_iv = 1'b0;
        repeat (5) step();
        check("stream_count", 32'(rx_a.size()), 32'd16);
        for (int i = 0; i < rx_a.size(); i++) check("stream_order", 32'(rx_a[i]), 32'(i + 1));

        // Backpressure with a full pipe
        a_ordy = 1'b0; a_iv = 1'b1;
        for (int n = 0; n < 3; n++) begin
            a_id = 8'(n + 1);
            step();
        end
        a_id = 8'h04;
        @(negedge clk);
        check("bp_ir", 32'(a_ir), 32'd0);
        check("bp_occ", 32'(a_occ), occ_exp(3));
        check("bp_ov", 32'(a_ov), 32'd1);
        check("bp_od", 32'(a_od), 32'h01);
        repeat (2) begin
            step();
            @(negedge clk);
            check("bp_hold_od", 32'(a_od), 32'h01);
            check("bp_hold_ir", 32'(a_ir), 32'd0);
        end
        rx_a.delete();
        step();
        a_ordy = 1'b1; a_iv = 1'b0;
        @(negedge clk);
        check("bp_release_ir", 32'(a_ir), 32'd1);
        repeat (4) step();
        check("bp_count", 32'(rx_a.size()), 32'd3);
        for (int i = 0; i < rx_a.size(); i++) check("bp_order", 32'(rx_a[i]), 32'(i + 1));

        // Bubble collapse: stages 1-2 full, stage 0 empty, output stalled
        a_ordy = 1'b0; a_iv = 1'b1; a_id = 8'h11;
        step();
        a_id = 8'h22;
        step();
        a_iv = 1'b0;
        step();
        a_iv = 1'b1; a_id = 8'h55;
        @(negedge clk);
        check("bub_ir", 32'(a_ir), 32'd1);
        check("bub_ov", 32'(a_ov), 32'd1);
        check("bub_od", 32'(a_od), 32'h11);
        check("bub_occ2", 32'(a_occ), occ_exp(2));
        step();
        @(negedge clk);
        check("bub_occ3", 32'(a_occ), occ_exp(3));
        check("bub_full_ir", 32'(a_ir), 32'd0);
        rx_a.delete();
        a_ordy = 1'b1; a_iv = 1'b0;
        repeat (5) step();
        check("bub_count", 32'(rx_a.size()), 32'd3);
        if (rx_a.size() == 3) begin
            check("bub_w0", 32'(rx_a[0]), 32'h11);
            check("bub_w1", 32'(rx_a[1]), 32'h22);
            check("bub_w2", 32'(rx_a[2]), 32'h55);
        end

        // Flush of a full pipe while 0x77 is presented
        a_ordy = 1'b0; a_iv = 1'b1;
        for (int n = 0; n < 3; n++) begin
            a_id = 8'(8'h31 + n);
            step();
        end
        a_flush = 1'b1; a_id = 8'h77;
        @(negedge clk);
        check("fl_ir", 32'(a_ir), 32'd0);
        check("fl_ov_during", 32'(a_ov), 32'd1);
        rx_a.delete();
        step();
        a_flush = 1'b0; a_iv = 1'b0; a_ordy = 1'b1;
        @(negedge clk);
        check("fl_ov_after", 32'(a_ov), 32'd0);
        check("fl_occ_after", 32'(a_occ), 32'd0);
        repeat (4) step();
        check("fl_nothing_out", 32'(rx_a.size()), 32'd0);

        // Random traffic on both DUTs, with one mid-stream reset
        for (int c = 0; c < 10000; c++) begin
            rst     = (c != 5000);
            a_iv    = 1'($urandom_range(0, 1));
            a_ordy  = 1'($urandom_range(0, 1));
            a_flush = ($urandom_range(0, 31) == 0);
            a_id    = 8'($urandom);
            b_iv    = 1'($urandom_range(0, 1));
            b_ordy  = 1'($urandom_range(0, 1));
            b_flush = 1'b0;
            b_id    = $urandom;
            step();
        end
        a_iv = 1'b0; b_iv = 1'b0; a_flush = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
